// File: rtl/wb_snoop_pkg.sv
// rtl/wb_snoop_pkg.sv - shared state encodings and snoop type constants for wb_snoop_ctrl
package wb_snoop_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_POLL = 3'b010,
        ST_RESP = 3'b100
    } snoop_state_e;

    localparam logic SNOOP_TYPE_IDLE = 1'b0;
    localparam logic SNOOP_TYPE_READ = 1'b1;

endpackage

// File: rtl/wb_snoop_prio_enc.sv
// rtl/wb_snoop_prio_enc.sv - lowest-index-wins priority encoder with found flag
module wb_snoop_prio_enc #(
    parameter int N  = 4,
    parameter int CW = 2
) (
    input  logic [N-1:0]  req_i,
    output logic          found_o,
    output logic [CW-1:0] idx_o
);

    // Scan from the top down so the lowest set bit is written last and wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                found_o = 1'b1;
                idx_o   = CW'(i);
            end
        end
    end

endmodule

// File: rtl/wb_snoop_ctrl.sv
// rtl/wb_snoop_ctrl.sv - snoop-read controller; optional POLL timeout under WB_SNOOP_TIMEOUT_EN
module wb_snoop_ctrl
    import wb_snoop_pkg::*;
#(
    parameter  int NUM_CORES = 4,
    parameter  int AW        = 32,
    parameter  int DW        = 32,
    parameter  int TIMEOUT   = 16,
    localparam int CW        = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [AW-1:0]           req_adr_i,
    input  logic [CW-1:0]           req_core_i,
    output logic [AW-1:0]           snoop_adr_o,
    output logic                    snoop_type_o,
    input  logic [NUM_CORES-1:0]    snoop_ack_i,
    input  logic [NUM_CORES-1:0]    snoop_hit_i,
    input  logic [NUM_CORES*DW-1:0] snoop_dat_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic                    rsp_hit_o,
    output logic [DW-1:0]           rsp_dat_o,
    output logic [CW-1:0]           rsp_src_o,
    output logic                    rsp_timeout_o
);

    snoop_state_e         state_q, state_d;
    logic [AW-1:0]        adr_q, adr_d;
    logic [NUM_CORES-1:0] own_q, own_d;
    logic [NUM_CORES-1:0] mask_q, mask_d;
    logic                 hit_q, hit_d;
    logic [DW-1:0]        dat_q, dat_d;
    logic [CW-1:0]        src_q, src_d;

    logic [NUM_CORES-1:0] acks;
    logic [NUM_CORES-1:0] hits;
    logic                 enc_found;
    logic [CW-1:0]        enc_idx;
    logic                 poll_done;
    logic                 poll_expired;

    // The requester's own ack/hit never counts; its mask bit is preset instead.
    assign acks = snoop_ack_i & ~own_q;
    assign hits = acks & snoop_hit_i;

    wb_snoop_prio_enc #(
        .N  (NUM_CORES),
        .CW (CW)
    ) u_prio_enc (
        .req_i   (hits),
        .found_o (enc_found),
        .idx_o   (enc_idx)
    );

`ifdef WB_SNOOP_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT + 1);
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            tmo_q, tmo_d;

    assign poll_expired  = (cnt_q == CNTW'(TIMEOUT - 1));
    assign rsp_timeout_o = tmo_q;
`else
    assign poll_expired  = 1'b0;
    assign rsp_timeout_o = 1'b0;
`endif

    assign poll_done = &(mask_q | acks);

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        own_d   = own_q;
        mask_d  = mask_q;
        hit_d   = hit_q;
        dat_d   = dat_q;
        src_d   = src_q;
`ifdef WB_SNOOP_TIMEOUT_EN
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    state_d = ST_POLL;
                    adr_d   = req_adr_i;
                    own_d   = NUM_CORES'(1) << req_core_i;
                    mask_d  = NUM_CORES'(1) << req_core_i;
                    hit_d   = 1'b0;
                    dat_d   = '0;
                    src_d   = '0;
`ifdef WB_SNOOP_TIMEOUT_EN
                    cnt_d   = '0;
                    tmo_d   = 1'b0;
`endif
                end
            end
            ST_POLL: begin
                mask_d = mask_q | acks;
                if (!hit_q && enc_found) begin
                    hit_d = 1'b1;
                    dat_d = snoop_dat_i[enc_idx*DW +: DW];
                    src_d = enc_idx;
                end
`ifdef WB_SNOOP_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
                if (poll_done) begin
                    state_d = ST_RESP;
                end else if (poll_expired) begin
                    state_d = ST_RESP;
`ifdef WB_SNOOP_TIMEOUT_EN
                    tmo_d   = 1'b1;
`endif
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            adr_q   <= '0;
            own_q   <= '0;
            mask_q  <= '0;
            hit_q   <= 1'b0;
            dat_q   <= '0;
            src_q   <= '0;
`ifdef WB_SNOOP_TIMEOUT_EN
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            own_q   <= own_d;
            mask_q  <= mask_d;
            hit_q   <= hit_d;
            dat_q   <= dat_d;
            src_q   <= src_d;
`ifdef WB_SNOOP_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    // Reset forces IDLE asynchronously, so ready must also be gated by reset itself.
    assign req_ready_o  = (state_q == ST_IDLE) && !wb_rst_i;
    assign snoop_type_o = (state_q == ST_POLL) ? SNOOP_TYPE_READ : SNOOP_TYPE_IDLE;
    assign snoop_adr_o  = adr_q;
    assign rsp_valid_o  = (state_q == ST_RESP);
    assign rsp_hit_o    = hit_q;
    assign rsp_dat_o    = dat_q;
    assign rsp_src_o    = src_q;

endmodule

// File: tb/tb_wb_snoop_ctrl.sv
// tb/tb_wb_snoop_ctrl.sv - directed self-checking bench for wb_snoop_ctrl
module tb_wb_snoop_ctrl;

    localparam int NC = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           req_valid;
    logic           req_ready;
    logic [AW-1:0]  req_adr;
    logic [CW-1:0]  req_core;
    logic [AW-1:0]  snoop_adr;
    logic           snoop_type;
    logic [NC-1:0]  snoop_ack;
    logic [NC-1:0]  snoop_hit;
    logic [NC*DW-1:0] snoop_dat;
    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_hit;
    logic [DW-1:0]  rsp_dat;
    logic [CW-1:0]  rsp_src;
    logic           rsp_timeout;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_snoop_ctrl #(
        .NUM_CORES (NC),
        .AW        (AW),
        .DW        (DW),
        .TIMEOUT   (16)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_adr_i     (req_adr),
        .req_core_i    (req_core),
        .snoop_adr_o   (snoop_adr),
        .snoop_type_o  (snoop_type),
        .snoop_ack_i   (snoop_ack),
        .snoop_hit_i   (snoop_hit),
        .snoop_dat_i   (snoop_dat),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_hit_o     (rsp_hit),
        .rsp_dat_o     (rsp_dat),
        .rsp_src_o     (rsp_src),
        .rsp_timeout_o (rsp_timeout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [AW-1:0] adr, input logic [CW-1:0] core);
        req_valid = 1'b1;
        req_adr   = adr;
        req_core  = core;
        step();
        req_valid = 1'b0;
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_adr   = '0;
        req_core  = '0;
        snoop_ack = '0;
        snoop_hit = '0;
        snoop_dat = '0;
        rsp_ready = 1'b0;
        step();
        step();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_snoop_type", snoop_type, 0);
        chk("rst_snoop_adr", snoop_adr, 0);
        chk("rst_rsp_hit", rsp_hit, 0);
        rst = 1'b0;
        #1;
        chk("idle_req_ready", req_ready, 1);

        // Core0 requests 0x100, all others ack with no hit in first POLL cycle
        accept(32'h100, 2'd0);
        chk("t1_snoop_type", snoop_type, 1);
        chk("t1_snoop_adr", snoop_adr, 32'h100);
        chk("t1_req_ready", req_ready, 0);
        chk("t1_rsp_valid_early", rsp_valid, 0);
        snoop_ack = 4'b1110;
        step();
        snoop_ack = '0;
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_hit", rsp_hit, 0);
        chk("t1_rsp_timeout", rsp_timeout, 0);
        chk("t1_rsp_dat", rsp_dat, 0);
        chk("t1_snoop_type_off", snoop_type, 0);
        handshake();
        chk("t1_rsp_valid_done", rsp_valid, 0);
        chk("t1_req_ready_back", req_ready, 1);

        // Core1 requests; core0 hits in cycle 1, cores 2/3 ack in cycle 3
        accept(32'h200, 2'd1);
        snoop_ack = 4'b0001;
        snoop_hit = 4'b0001;
        snoop_dat = {32'h0, 32'h0, 32'h0, 32'h40};
        step();
        snoop_ack = '0;
        snoop_hit = '0;
        snoop_dat = '0;
        chk("t2_c1_rsp_valid", rsp_valid, 0);
        step();
        chk("t2_c2_rsp_valid", rsp_valid, 0);
        snoop_ack = 4'b1100;
        step();
        snoop_ack = '0;
        chk("t2_rsp_valid", rsp_valid, 1);
        chk("t2_rsp_hit", rsp_hit, 1);
        chk("t2_rsp_dat", rsp_dat, 32'h40);
        chk("t2_rsp_src", rsp_src, 0);

        // Backpressure: response held while a new request waits
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_adr   = 32'h300;
        req_core  = 2'd2;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_hold_valid", rsp_valid, 1);
            chk("t3_hold_dat", rsp_dat, 32'h40);
            chk("t3_hold_src", rsp_src, 0);
            chk("t3_hold_hit", rsp_hit, 1);
            chk("t3_hold_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("t3_after_hs_valid", rsp_valid, 0);
        chk("t3_after_hs_ready", req_ready, 1);
        chk("t3_after_hs_type", snoop_type, 0);
        step();
        req_valid = 1'b0;
        chk("t3_accept_type", snoop_type, 1);
        chk("t3_accept_adr", snoop_adr, 32'h300);

        // Hit without ack is ignored; requester (core2) not needed in ack set
        snoop_ack = 4'b0000;
        snoop_hit = 4'b1111;
        snoop_dat = {32'h44, 32'h33, 32'h22, 32'h11};
        step();
        snoop_hit = '0;
        snoop_ack = 4'b1011;
        step();
        snoop_ack = '0;
        snoop_dat = '0;
        chk("t4_rsp_valid", rsp_valid, 1);
        chk("t4_rsp_hit", rsp_hit, 0);
        chk("t4_rsp_dat", rsp_dat, 0);
        chk("t4_rsp_src", rsp_src, 0);
        handshake();

        // Cores 2 and 3 hit together; own hit of core0 and later core1 hit ignored
        accept(32'h400, 2'd0);
        snoop_ack = 4'b1101;
        snoop_hit = 4'b1101;
        snoop_dat = {32'h33, 32'h22, 32'h0, 32'h99};
        step();
        chk("t5_c1_rsp_valid", rsp_valid, 0);
        snoop_ack = 4'b0010;
        snoop_hit = 4'b0010;
        snoop_dat = {32'h0, 32'h0, 32'h11, 32'h0};
        step();
        snoop_ack = '0;
        snoop_hit = '0;
        snoop_dat = '0;
        chk("t5_rsp_valid", rsp_valid, 1);
        chk("t5_rsp_hit", rsp_hit, 1);
        chk("t5_rsp_src", rsp_src, 2);
        chk("t5_rsp_dat", rsp_dat, 32'h22);
        handshake();

        // Only core1 ever acks
        accept(32'h500, 2'd0);
        snoop_ack = 4'b0010;
`ifdef WB_SNOOP_TIMEOUT_EN
        for (int i = 0; i < 15; i++) step();
        chk("t6_before_timeout", rsp_valid, 0);
        step();
        chk("t6_timeout_valid", rsp_valid, 1);
        chk("t6_timeout_flag", rsp_timeout, 1);
        chk("t6_timeout_hit", rsp_hit, 0);
        snoop_ack = '0;
        handshake();
        accept(32'h600, 2'd1);
`else
        for (int i = 0; i < 20; i++) step();
        chk("t6_still_poll_type", snoop_type, 1);
        chk("t6_still_poll_valid", rsp_valid, 0);
        chk("t6_no_timeout", rsp_timeout, 0);
        snoop_ack = '0;
`endif

        // Reset pulse while polling
        chk("t7_pre_rst_type", snoop_type, 1);
        rst = 1'b1;
        #1;
        chk("t7_rst_type", snoop_type, 0);
        chk("t7_rst_valid", rsp_valid, 0);
        chk("t7_rst_ready", req_ready, 0);
        chk("t7_rst_adr", snoop_adr, 0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("t7_release_ready", req_ready, 1);
        chk("t7_release_type", snoop_type, 0);

        // Normal operation resumes after reset
        accept(32'h700, 2'd3);
        snoop_ack = 4'b0111;
        step();
        snoop_ack = '0;
        chk("t8_rsp_valid", rsp_valid, 1);
        chk("t8_rsp_hit", rsp_hit, 0);
        chk("t8_snoop_adr", snoop_adr, 32'h700);
        handshake();
        chk("t8_idle_ready", req_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
